// File: rtl/riscv_regfile_pkg.sv
// Shared constants and helpers for the parametrised RISC-V register file.
package riscv_regfile_pkg;

   // Architectural register names used by decode and the bench
   localparam int REG_ZERO = 0;
   localparam int REG_RA   = 1;
   localparam int REG_SP   = 2;

   // Legal register counts: full RV32I file or the reduced RV32E file
   localparam int NUM_REGS_RV32I = 32;
   localparam int NUM_REGS_RV32E = 16;

   // Low bit of port p inside a flattened multi-port vector
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

endpackage

// File: rtl/riscv_regfile_sb_if.sv
// Decode/issue and writeback signals of the register file, bundled for port lists.
interface riscv_regfile_sb_if #(
   parameter int XLEN         = 32,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2
);
   localparam int AW = $clog2(NUM_REGS);

   logic                         wr_en_i;
   logic [AW-1:0]                wr_addr_i;
   logic [XLEN-1:0]              wr_data_i;
   logic [NUM_RD_PORTS*AW-1:0]   rd_addr_i;
   logic [NUM_RD_PORTS*XLEN-1:0] rd_data_o;
   logic [NUM_RD_PORTS-1:0]      rd_busy_o;
   logic                         issue_valid_i;
   logic [AW-1:0]                issue_rd_i;
   logic                         issue_ready_o;
   logic [AW:0]                  pending_cnt_o;

   // Pipeline side: decode/issue and writeback drive requests, sample results
   modport master (
      output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, issue_valid_i, issue_rd_i,
      input  rd_data_o, rd_busy_o, issue_ready_o, pending_cnt_o
   );

   // Register file side
   modport slave (
      input  wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, issue_valid_i, issue_rd_i,
      output rd_data_o, rd_busy_o, issue_ready_o, pending_cnt_o
   );
endinterface

// File: rtl/riscv_regfile_scoreboard.sv
// Per-register busy tracking: set on issue, clear on writeback, set wins on a tie.
module riscv_regfile_scoreboard
   import riscv_regfile_pkg::*;
#(
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS       = 1,
   localparam int AW          = $clog2(NUM_REGS)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       wr_en,
   input  logic [AW-1:0]              wr_addr,
   input  logic                       issue_valid,
   input  logic [AW-1:0]              issue_rd,
   input  logic [NUM_RD_PORTS*AW-1:0] rd_addr,
   output logic [NUM_RD_PORTS-1:0]    rd_busy,
   output logic                       issue_ready,
   output logic [AW:0]                pending_cnt
);

   localparam logic BYP_EN = (BYPASS != 0);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [AW:0]         pending_cnt_q;
   logic                wr_hit;
   logic                issue_fire;

   assign wr_hit     = wr_en && (wr_addr != AW'(REG_ZERO));
   assign issue_fire = issue_valid && issue_ready && (issue_rd != AW'(REG_ZERO));

   // A writeback to the issuing register frees the slot this cycle, so WAW stalls only
   // against a write that is still outstanding.
   assign issue_ready = (issue_rd == AW'(REG_ZERO)) || !busy_q[issue_rd]
                        || (wr_en && (wr_addr == issue_rd));

   // Next busy vector: clear first, then set, so a same-cycle issue keeps the flag
   always_comb begin
      // NOTE: default the whole vector first so no path leaves it unassigned (no latch).
      busy_d = busy_q;
      if (wr_hit)
         busy_d[wr_addr] = 1'b0;
      if (issue_fire)
         busy_d[issue_rd] = 1'b1;
   end

   // Busy flags and their registered population count
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q        <= '0;
         pending_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples
         // the pre-edge values regardless of statement order.
         busy_q        <= busy_d;
         pending_cnt_q <= (AW+1)'($countones(busy_d));
      end
   end

   assign pending_cnt = pending_cnt_q;

   // Per-port hazard lookup; a bypassed writeback hides the flag it is about to clear
   always_comb begin
      rd_busy = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         rd_busy[p] = busy_q[rd_addr[slice_lo(p, AW) +: AW]]
                      && !(BYP_EN && wr_en && (wr_addr == rd_addr[slice_lo(p, AW) +: AW]));
      end
   end

endmodule

// File: rtl/riscv_regfile_sb.sv
// Parametrised integer register file with write-to-read bypass and a hazard scoreboard.
module riscv_regfile_sb
   import riscv_regfile_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int NUM_REGS     = 32,
   parameter int NUM_RD_PORTS = 2,
   parameter int BYPASS       = 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   riscv_regfile_sb_if.slave  bus
);

   localparam int AW = $clog2(NUM_REGS);

   if (NUM_REGS != NUM_REGS_RV32I && NUM_REGS != NUM_REGS_RV32E) begin : g_bad_num_regs
      $error("riscv_regfile_sb: NUM_REGS must be 16 or 32");
   end
   if (NUM_RD_PORTS < 1 || NUM_RD_PORTS > 4) begin : g_bad_rd_ports
      $error("riscv_regfile_sb: NUM_RD_PORTS must be in 1..4");
   end

   // x0 is hard-wired, so storage starts at x1
   logic [XLEN-1:0]              regs_q [1:NUM_REGS-1];
   logic [NUM_RD_PORTS*XLEN-1:0] rd_data;
   logic                         wr_hit;
   logic                         byp_en;

   assign wr_hit = bus.wr_en_i && (bus.wr_addr_i != AW'(REG_ZERO));
   // Forwarding is suppressed while in reset so reads show the cleared array
   assign byp_en = (BYPASS != 0) && rst_ni && bus.wr_en_i;

   // Data array: cleared by reset, one writeback per cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: the array is reset because software may read any register before
         // writing it and must see zero; this forces flops rather than RAM macros.
         for (int i = 1; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else if (wr_hit) begin
         regs_q[bus.wr_addr_i] <= bus.wr_data_i;
      end
   end

   // Read muxes: x0 returns zero, a same-cycle write to the address is forwarded
   always_comb begin
      rd_data = '0;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
         if (bus.rd_addr_i[slice_lo(p, AW) +: AW] != AW'(REG_ZERO)) begin
            if (byp_en && (bus.wr_addr_i == bus.rd_addr_i[slice_lo(p, AW) +: AW]))
               rd_data[slice_lo(p, XLEN) +: XLEN] = bus.wr_data_i;
            else
               rd_data[slice_lo(p, XLEN) +: XLEN] = regs_q[bus.rd_addr_i[slice_lo(p, AW) +: AW]];
         end
      end
   end

   assign bus.rd_data_o = rd_data;

   riscv_regfile_scoreboard #(
      .NUM_REGS     (NUM_REGS),
      .NUM_RD_PORTS (NUM_RD_PORTS),
      .BYPASS       (BYPASS)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_en        (bus.wr_en_i),
      .wr_addr      (bus.wr_addr_i),
      .issue_valid  (bus.issue_valid_i),
      .issue_rd     (bus.issue_rd_i),
      .rd_addr      (bus.rd_addr_i),
      .rd_busy      (bus.rd_busy_o),
      .issue_ready  (bus.issue_ready_o),
      .pending_cnt  (bus.pending_cnt_o)
   );

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed bench for riscv_regfile_sb: RV32I 2-port and RV32E 3-port instances.
module tb_riscv_regfile_sb;
   import riscv_regfile_pkg::*;

   logic clk;
   logic rst_n;
   int   vectors;
   int   miscompares;

   riscv_regfile_sb_if #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2)) bus32 ();
   riscv_regfile_sb_if #(.XLEN(32), .NUM_REGS(16), .NUM_RD_PORTS(3)) bus16 ();

   riscv_regfile_sb #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(1)) dut32 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus32)
   );

   riscv_regfile_sb #(.XLEN(32), .NUM_REGS(16), .NUM_RD_PORTS(3), .BYPASS(1)) dut16 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle32();
      bus32.wr_en_i       = 1'b0;
      bus32.wr_addr_i     = '0;
      bus32.wr_data_i     = '0;
      bus32.issue_valid_i = 1'b0;
      bus32.issue_rd_i    = '0;
   endtask

   task automatic idle16();
      bus16.wr_en_i       = 1'b0;
      bus16.wr_addr_i     = '0;
      bus16.wr_data_i     = '0;
      bus16.issue_valid_i = 1'b0;
      bus16.issue_rd_i    = '0;
      bus16.rd_addr_i     = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle16();
      bus32.wr_en_i       = 1'b1;
      bus32.wr_addr_i     = 5'd5;
      bus32.wr_data_i     = 32'hDEAD;
      bus32.issue_valid_i = 1'b1;
      bus32.issue_rd_i    = 5'd4;
      bus32.rd_addr_i     = {5'd4, 5'd5};
      tick();
      tick();
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h0) begin miscompares++;
         $display("FAIL rst_bypass_gated: got %h expected %h", bus32.rd_data_o[31:0], 32'h0); end
      vectors++; if (bus32.rd_busy_o !== 2'b00) begin miscompares++;
         $display("FAIL rst_rd_busy: got %b expected %b", bus32.rd_busy_o, 2'b00); end
      vectors++; if (bus32.issue_ready_o !== 1'b1) begin miscompares++;
         $display("FAIL rst_issue_ready: got %b expected %b", bus32.issue_ready_o, 1'b1); end
      vectors++; if (bus32.pending_cnt_o !== 6'd0) begin miscompares++;
         $display("FAIL rst_pending: got %0d expected %0d", bus32.pending_cnt_o, 0); end
      idle32();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h0) begin miscompares++;
         $display("FAIL post_rst_x5: got %h expected %h", bus32.rd_data_o[31:0], 32'h0); end
      vectors++; if (bus32.pending_cnt_o !== 6'd0) begin miscompares++;
         $display("FAIL post_rst_pending: got %0d expected %0d", bus32.pending_cnt_o, 0); end
   endtask

   task automatic test_write_bypass();
      bus32.wr_en_i   = 1'b1;
      bus32.wr_addr_i = 5'd7;
      bus32.wr_data_i = 32'h1234;
      bus32.rd_addr_i = {5'd0, 5'd7};
      #1;
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h1234) begin miscompares++;
         $display("FAIL bypass_x7: got %h expected %h", bus32.rd_data_o[31:0], 32'h1234); end
      vectors++; if (bus32.rd_data_o[63:32] !== 32'h0) begin miscompares++;
         $display("FAIL read_x0_p1: got %h expected %h", bus32.rd_data_o[63:32], 32'h0); end
      tick();
      idle32();
      #1;
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h1234) begin miscompares++;
         $display("FAIL stored_x7: got %h expected %h", bus32.rd_data_o[31:0], 32'h1234); end
      bus32.wr_en_i   = 1'b1;
      bus32.wr_addr_i = 5'd0;
      bus32.wr_data_i = 32'hFFFF;
      bus32.rd_addr_i = {5'd7, 5'd0};
      #1;
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h0) begin miscompares++;
         $display("FAIL x0_write_bypass: got %h expected %h", bus32.rd_data_o[31:0], 32'h0); end
      tick();
      idle32();
      #1;
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h0) begin miscompares++;
         $display("FAIL x0_after_write: got %h expected %h", bus32.rd_data_o[31:0], 32'h0); end
      vectors++; if (bus32.rd_data_o[63:32] !== 32'h1234) begin miscompares++;
         $display("FAIL x7_port1: got %h expected %h", bus32.rd_data_o[63:32], 32'h1234); end
      vectors++; if (bus32.pending_cnt_o !== 6'd0) begin miscompares++;
         $display("FAIL nonbusy_wb_pending: got %0d expected %0d", bus32.pending_cnt_o, 0); end
   endtask

   task automatic test_scoreboard();
      bus32.issue_valid_i = 1'b1;
      bus32.issue_rd_i    = 5'd3;
      bus32.rd_addr_i     = {5'd3, 5'd7};
      #1;
      vectors++; if (bus32.issue_ready_o !== 1'b1) begin miscompares++;
         $display("FAIL sb_first_ready: got %b expected %b", bus32.issue_ready_o, 1'b1); end
      tick();
      vectors++; if (bus32.rd_busy_o !== 2'b10) begin miscompares++;
         $display("FAIL sb_busy_x3: got %b expected %b", bus32.rd_busy_o, 2'b10); end
      vectors++; if (bus32.pending_cnt_o !== 6'd1) begin miscompares++;
         $display("FAIL sb_pending_1: got %0d expected %0d", bus32.pending_cnt_o, 1); end
      vectors++; if (bus32.issue_ready_o !== 1'b0) begin miscompares++;
         $display("FAIL sb_waw_stall: got %b expected %b", bus32.issue_ready_o, 1'b0); end
      tick();
      vectors++; if (bus32.pending_cnt_o !== 6'd1) begin miscompares++;
         $display("FAIL sb_stall_pending: got %0d expected %0d", bus32.pending_cnt_o, 1); end
      bus32.issue_valid_i = 1'b0;
      bus32.wr_en_i       = 1'b1;
      bus32.wr_addr_i     = 5'd3;
      bus32.wr_data_i     = 32'h33;
      #1;
      vectors++; if (bus32.rd_busy_o !== 2'b00) begin miscompares++;
         $display("FAIL sb_wb_busy_bypass: got %b expected %b", bus32.rd_busy_o, 2'b00); end
      vectors++; if (bus32.issue_ready_o !== 1'b1) begin miscompares++;
         $display("FAIL sb_wb_ready: got %b expected %b", bus32.issue_ready_o, 1'b1); end
      tick();
      idle32();
      #1;
      vectors++; if (bus32.rd_busy_o !== 2'b00) begin miscompares++;
         $display("FAIL sb_cleared: got %b expected %b", bus32.rd_busy_o, 2'b00); end
      vectors++; if (bus32.pending_cnt_o !== 6'd0) begin miscompares++;
         $display("FAIL sb_pending_0: got %0d expected %0d", bus32.pending_cnt_o, 0); end
      vectors++; if (bus32.rd_data_o[63:32] !== 32'h33) begin miscompares++;
         $display("FAIL sb_x3_data: got %h expected %h", bus32.rd_data_o[63:32], 32'h33); end
   endtask

   task automatic test_simultaneous();
      bus32.issue_valid_i = 1'b1;
      bus32.issue_rd_i    = 5'd9;
      bus32.rd_addr_i     = {5'd0, 5'd9};
      tick();
      bus32.wr_en_i   = 1'b1;
      bus32.wr_addr_i = 5'd9;
      bus32.wr_data_i = 32'hA5A5;
      #1;
      vectors++; if (bus32.issue_ready_o !== 1'b1) begin miscompares++;
         $display("FAIL sim_ready: got %b expected %b", bus32.issue_ready_o, 1'b1); end
      tick();
      idle32();
      #1;
      vectors++; if (bus32.rd_data_o[31:0] !== 32'hA5A5) begin miscompares++;
         $display("FAIL sim_x9_data: got %h expected %h", bus32.rd_data_o[31:0], 32'hA5A5); end
      vectors++; if (bus32.rd_busy_o !== 2'b01) begin miscompares++;
         $display("FAIL sim_busy_kept: got %b expected %b", bus32.rd_busy_o, 2'b01); end
      vectors++; if (bus32.pending_cnt_o !== 6'd1) begin miscompares++;
         $display("FAIL sim_pending: got %0d expected %0d", bus32.pending_cnt_o, 1); end
      bus32.wr_en_i   = 1'b1;
      bus32.wr_addr_i = 5'd9;
      bus32.wr_data_i = 32'h99;
      tick();
      idle32();
   endtask

   task automatic test_mid_reset();
      bus32.issue_valid_i = 1'b1;
      bus32.issue_rd_i    = 5'(REG_RA);
      tick();
      bus32.issue_rd_i    = 5'(REG_SP);
      tick();
      bus32.issue_rd_i    = 5'd31;
      tick();
      idle32();
      bus32.issue_rd_i = 5'(REG_SP);
      bus32.rd_addr_i  = {5'd7, 5'(REG_RA)};
      #1;
      vectors++; if (bus32.pending_cnt_o !== 6'd3) begin miscompares++;
         $display("FAIL mid_pending_3: got %0d expected %0d", bus32.pending_cnt_o, 3); end
      vectors++; if (bus32.issue_ready_o !== 1'b0) begin miscompares++;
         $display("FAIL mid_x2_stall: got %b expected %b", bus32.issue_ready_o, 1'b0); end
      rst_n = 1'b0;
      #1;
      vectors++; if (bus32.rd_busy_o !== 2'b00) begin miscompares++;
         $display("FAIL mid_busy_cleared: got %b expected %b", bus32.rd_busy_o, 2'b00); end
      vectors++; if (bus32.issue_ready_o !== 1'b1) begin miscompares++;
         $display("FAIL mid_ready: got %b expected %b", bus32.issue_ready_o, 1'b1); end
      vectors++; if (bus32.pending_cnt_o !== 6'd0) begin miscompares++;
         $display("FAIL mid_pending_0: got %0d expected %0d", bus32.pending_cnt_o, 0); end
      vectors++; if (bus32.rd_data_o[63:32] !== 32'h0) begin miscompares++;
         $display("FAIL mid_x7_cleared: got %h expected %h", bus32.rd_data_o[63:32], 32'h0); end
      #1;
      rst_n = 1'b1;
      bus32.wr_en_i   = 1'b1;
      bus32.wr_addr_i = 5'(REG_RA);
      bus32.wr_data_i = 32'h11;
      tick();
      idle32();
      #1;
      vectors++; if (bus32.pending_cnt_o !== 6'd0) begin miscompares++;
         $display("FAIL mid_late_wb_pending: got %0d expected %0d", bus32.pending_cnt_o, 0); end
      vectors++; if (bus32.rd_data_o[31:0] !== 32'h11) begin miscompares++;
         $display("FAIL mid_late_wb_data: got %h expected %h", bus32.rd_data_o[31:0], 32'h11); end
   endtask

   task automatic test_rv32e();
      bus16.wr_en_i   = 1'b1;
      bus16.wr_addr_i = 4'd15;
      bus16.wr_data_i = 32'hCAFE;
      bus16.rd_addr_i = {4'd15, 4'd15, 4'd15};
      #1;
      for (int p = 0; p < 3; p++) begin
         vectors++; if (bus16.rd_data_o[p*32 +: 32] !== 32'hCAFE) begin miscompares++;
            $display("FAIL e_bypass_p%0d: got %h expected %h", p, bus16.rd_data_o[p*32 +: 32], 32'hCAFE); end
      end
      tick();
      idle16();
      bus16.rd_addr_i = {4'd15, 4'd15, 4'd15};
      #1;
      for (int p = 0; p < 3; p++) begin
         vectors++; if (bus16.rd_data_o[p*32 +: 32] !== 32'hCAFE) begin miscompares++;
            $display("FAIL e_stored_p%0d: got %h expected %h", p, bus16.rd_data_o[p*32 +: 32], 32'hCAFE); end
      end
      for (int r = 1; r < 16; r++) begin
         bus16.issue_valid_i = 1'b1;
         bus16.issue_rd_i    = 4'(r);
         tick();
      end
      idle16();
      bus16.issue_rd_i = 4'd15;
      bus16.rd_addr_i  = {4'd0, 4'd8, 4'd15};
      #1;
      vectors++; if (bus16.pending_cnt_o !== 5'd15) begin miscompares++;
         $display("FAIL e_pending_15: got %0d expected %0d", bus16.pending_cnt_o, 15); end
      vectors++; if (bus16.rd_busy_o !== 3'b011) begin miscompares++;
         $display("FAIL e_rd_busy: got %b expected %b", bus16.rd_busy_o, 3'b011); end
      vectors++; if (bus16.issue_ready_o !== 1'b0) begin miscompares++;
         $display("FAIL e_ready_x15: got %b expected %b", bus16.issue_ready_o, 1'b0); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_write_bypass();
      test_scoreboard();
      test_simultaneous();
      test_mid_reset();
      test_rv32e();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Parametrised integer register file with a built-in register scoreboard, succeeding the fixed 32x32 2R1W file in the RISC-V base core. It adds:
- configurable XLEN, register count (RV32I/RV32E) and read-port count;
- an explicit write enable;
- write-to-read bypass;
- per-register busy tracking, so decode can stall on RAW/WAW hazards against long-latency writebacks.

It sits between decode/issue (read ports, issue port) and writeback (write port).

## Interface
Parameters:
- XLEN, 32, register width in bits
- NUM_REGS, 32, architectural register count; 32 or 16 only (RV32E). AW = $clog2(NUM_REGS)
- NUM_RD_PORTS, 2, number of read ports; range 1..4
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- wr_en_i  in  1  writeback valid
- wr_addr_i  in  AW  writeback destination
- wr_data_i  in  XLEN  writeback data
- rd_addr_i  in  NUM_RD_PORTS*AW  read addresses, port p at [p*AW +: AW]
- rd_data_o  out  NUM_RD_PORTS*XLEN  read data, port p at [p*XLEN +: XLEN]
- rd_busy_o  out  NUM_RD_PORTS  port p reads a register with a pending write
- issue_valid_i  in  1  issuing instruction will write issue_rd_i later
- issue_rd_i  in  AW  destination of issuing instruction
- issue_ready_o  out  1  issue may be accepted this cycle
- pending_cnt_o  out  AW+1  number of busy registers (registered)

## Operation
- Storage: registers 1..NUM_REGS-1, XLEN bits each. x0 has no storage.
  - x0 always reads 0.
  - x0 is never busy.
  - Writes and issues to x0 update no state.
- Write: on a rising edge with wr_en_i=1 and wr_addr_i!=0, reg[wr_addr_i] <= wr_data_i.
- Read (combinational), per port p, with a = rd_addr_i[p]:
  - a==0: 0.
  - Else if BYPASS and wr_en_i and wr_addr_i==a: wr_data_i.
  - Else: reg[a].
- Busy flag per register, busy_q[1..NUM_REGS-1]:
  - Issue fire = issue_valid_i & issue_ready_o. On fire with issue_rd_i!=0, set busy_q[issue_rd_i].
  - wr_en_i with wr_addr_i!=0 clears busy_q[wr_addr_i].
  - Same register hit by fire and write in one cycle: set wins, so busy stays 1. The data is still written.
  - Writeback to a non-busy register is legal: data written, busy unchanged.
- rd_busy_o[p] = busy_q[a] & ~(BYPASS & wr_en_i & wr_addr_i==a). It is 0 for a==0.
- issue_ready_o = (issue_rd_i==0) | ~busy_q[issue_rd_i] | (wr_en_i & wr_addr_i==issue_rd_i). This blocks a WAW against an outstanding write. issue_valid_i does not affect issue_ready_o.
- pending_cnt_o is the registered popcount of next-state busy_q. It equals the number of busy flags one cycle after the update.

## Timing
- Reads, rd_busy_o and issue_ready_o are combinational (0-cycle).
- A write is visible to the register array on the next cycle. With BYPASS, it is also visible to reads in the same cycle.
- Busy set/clear takes effect on the next edge. pending_cnt_o updates on the same edge as busy_q.
- While rst_ni=0 (asynchronous):
  - all registers = 0, busy_q = 0, pending_cnt_o = 0;
  - bypass is gated off, so rd_data_o = 0;
  - rd_busy_o = 0, issue_ready_o = 1;
  - writes and issues are ignored.
- Reset asserted mid-operation discards all pending-write state immediately. Later writebacks to those registers only write data.
- Release: first state update on the first rising edge with rst_ni=1.

## Structure
- Package riscv_regfile_pkg holds:
  - REG_ZERO = 0, REG_RA = 1, REG_SP = 2;
  - the NUM_REGS legal-value constants (32, 16);
  - a function for the port-slice index.
- Sub-module riscv_regfile_scoreboard holds busy_q, the set/clear priority, issue_ready_o, the rd_busy_o lookup and the pending_cnt_o popcount.
- The top holds the data array, read muxes and bypass.
- Elaboration error if NUM_REGS is not 16/32 or NUM_RD_PORTS is outside 1..4.

## Test plan
- Reset then read: rst_ni=0 with wr_en_i=1, wr_addr_i=5, wr_data_i=32'hDEAD -> rd_data_o=0 and pending_cnt_o=0 after release. A read of x5 returns 0.
- Write/read plus bypass: write x7=32'h1234 while port 0 reads x7 -> port 0 shows 32'h1234 the same cycle and next cycle. Writing x0=32'hFFFF -> x0 reads 0.
- Scoreboard: issue rd=3 -> next cycle rd_busy_o=1 for a port reading x3 and pending_cnt_o=1. A second issue to x3 sees issue_ready_o=0. Writeback to x3 -> busy clears, pending_cnt_o=0.
- Simultaneous: x9 busy, same cycle writeback x9=32'hA5A5 and issue rd=9 -> issue accepted, x9 reads 32'hA5A5, busy stays 1, pending_cnt_o stays 1.
- Mid-operation reset: issue x1, x2, x31 (pending_cnt_o=3), pulse rst_ni low between edges -> all busy cleared immediately, count 0, issue_ready_o=1.
- RV32E config (NUM_REGS=16, NUM_RD_PORTS=3): all three ports read x15 after a write of 32'hCAFE -> all return 32'hCAFE. Issue to all 15 registers -> pending_cnt_o=15.
